// File: rtl/stack_ctrl.sv
// Hardware stack controller: maps push/pop commands onto a registered-read RAM,
// owns the stack pointer, returns popped words and keeps sticky error flags.
module stack_ctrl #(
  parameter int                   addr_size   = 8,
  parameter int                   data_size   = 8,
  parameter logic [addr_size-1:0] stack_base  = 8'hC0,
  parameter int                   stack_depth = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [data_size-1:0] push_data,
  output logic                 ready,
  output logic [data_size-1:0] pop_data,
  output logic                 pop_valid,
  output logic [addr_size-1:0] sp,
  output logic [addr_size:0]   count,
  output logic                 empty,
  output logic                 full,
  output logic [2:0]           err,
  input  logic                 err_clr,
  output logic                 ram_write_en,
  output logic [addr_size-1:0] ram_write_adress,
  output logic [data_size-1:0] ram_data_in,
  output logic                 ram_rd_en,
  output logic [addr_size-1:0] ram_rd_adress,
  input  logic [data_size-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  localparam logic [addr_size:0]   depth_c   = (addr_size+1)'(stack_depth);
  localparam logic [addr_size:0]   cnt_one_c = (addr_size+1)'(1);
  localparam logic [addr_size-1:0] sp_one_c  = addr_size'(1);

  state_t               state_q, state_d;
  logic [addr_size:0]   count_q, count_d;
  logic [addr_size-1:0] sp_q, sp_d;
  logic [2:0]           err_q, err_d;
  logic [data_size-1:0] pop_data_q, pop_data_d;

  assign empty     = (count_q == '0);
  assign full      = (count_q == depth_c);
  assign count     = count_q;
  assign sp        = sp_q;
  assign err       = err_q;
  assign pop_data  = pop_data_q;
  assign ready     = (state_q != RD_WAIT);
  assign pop_valid = (state_q == RESP);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d          = state_q;
    count_d          = count_q;
    sp_d             = sp_q;
    pop_data_d       = pop_data_q;
    err_d            = err_clr ? 3'b000 : err_q;
    ram_write_en     = 1'b0;
    ram_write_adress = sp_q;
    ram_data_in      = push_data;
    ram_rd_en        = 1'b0;
    ram_rd_adress    = sp_q - sp_one_c;

    case (state_q)
      RD_WAIT: begin
        pop_data_d = ram_data_out;
        state_d    = RESP;
      end
      default: begin
        // IDLE and RESP accept commands identically; a push always beats a pop.
        state_d = IDLE;
        if (push) begin
          if (full) begin
            err_d[0] = 1'b1;
          end else begin
            ram_write_en = 1'b1;
            count_d      = count_q + cnt_one_c;
            sp_d         = sp_q + sp_one_c;
          end
          if (pop) err_d[2] = 1'b1;
        end else if (pop) begin
          if (empty) begin
            err_d[1] = 1'b1;
          end else begin
            ram_rd_en = 1'b1;
            count_d   = count_q - cnt_one_c;
            sp_d      = sp_q - sp_one_c;
            state_d   = RD_WAIT;
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      sp_q       <= stack_base;
      err_q      <= 3'b000;
      pop_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sp_q       <= sp_d;
      err_q      <= err_d;
      pop_data_q <= pop_data_d;
    end
  end

endmodule
